// File: rtl/cond_exec_stage.sv
// Execute-stage back end: NZCV flag register, condition evaluation, side-effect
// gating and the Execute/Memory pipeline register.
module cond_exec_stage #(
    parameter int BITS = 32,
    parameter int RA   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallM,
    input  logic            FlushM,
    input  logic [3:0]      CondE,
    input  logic [1:0]      FlagWriteE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            MemtoRegE,
    input  logic            PCSrcE,
    input  logic [3:0]      ALUFlags,
    input  logic [BITS-1:0] ALUResultE,
    input  logic [BITS-1:0] WriteDataE,
    input  logic [RA-1:0]   WA3E,
    output logic            CondExE,
    output logic            BranchTakenE,
    output logic [3:0]      Flags,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            MemtoRegM,
    output logic            PCSrcM,
    output logic [BITS-1:0] ALUOutM,
    output logic [BITS-1:0] WriteDataM,
    output logic [RA-1:0]   WA3M
);

    logic [3:0]      flags_reg;
    logic [3:0]      flags_next;
    logic            cond_ex;
    logic            flag_we;
    logic            reg_write_reg, mem_write_reg, mem_to_reg_reg, pc_src_reg;
    logic [BITS-1:0] alu_out_reg, write_data_reg;
    logic [RA-1:0]   wa3_reg;

    logic n_flag, z_flag, c_flag, v_flag;
    assign {n_flag, z_flag, c_flag, v_flag} = flags_reg;

    // Condition is judged against the committed flags only, so a flag-setting
    // instruction directly ahead is seen one cycle later without forwarding.
    always_comb begin
        cond_ex = 1'b0;
        case (CondE)
            4'h0: cond_ex = z_flag;
            4'h1: cond_ex = ~z_flag;
            4'h2: cond_ex = c_flag;
            4'h3: cond_ex = ~c_flag;
            4'h4: cond_ex = n_flag;
            4'h5: cond_ex = ~n_flag;
            4'h6: cond_ex = v_flag;
            4'h7: cond_ex = ~v_flag;
            4'h8: cond_ex = c_flag & ~z_flag;
            4'h9: cond_ex = ~c_flag | z_flag;
            4'hA: cond_ex = (n_flag == v_flag);
            4'hB: cond_ex = (n_flag != v_flag);
            4'hC: cond_ex = ~z_flag & (n_flag == v_flag);
            4'hD: cond_ex = z_flag | (n_flag != v_flag);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign CondExE      = cond_ex;
    assign BranchTakenE = PCSrcE & cond_ex & ~FlushM;
    assign flag_we      = ~StallM & ~FlushM & cond_ex;

    // Half 1 is {N,Z}, half 0 is {C,V}; each has its own write enable.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_flag_half
            assign flags_next[gi*2 +: 2] = (flag_we & FlagWriteE[gi]) ?
                                           ALUFlags[gi*2 +: 2] : flags_reg[gi*2 +: 2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_reg <= 4'b0000;
        end else begin
            flags_reg <= flags_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_reg  <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            pc_src_reg     <= 1'b0;
            alu_out_reg    <= '0;
            write_data_reg <= '0;
            wa3_reg        <= '0;
        end else if (!StallM) begin
            if (FlushM) begin
                reg_write_reg  <= 1'b0;
                mem_write_reg  <= 1'b0;
                mem_to_reg_reg <= 1'b0;
                pc_src_reg     <= 1'b0;
                alu_out_reg    <= '0;
                write_data_reg <= '0;
                wa3_reg        <= '0;
            end else begin
                reg_write_reg  <= RegWriteE & cond_ex;
                mem_write_reg  <= MemWriteE & cond_ex;
                mem_to_reg_reg <= MemtoRegE;
                pc_src_reg     <= PCSrcE & cond_ex;
                alu_out_reg    <= ALUResultE;
                write_data_reg <= WriteDataE;
                wa3_reg        <= WA3E;
            end
        end
    end

    assign Flags      = flags_reg;
    assign RegWriteM  = reg_write_reg;
    assign MemWriteM  = mem_write_reg;
    assign MemtoRegM  = mem_to_reg_reg;
    assign PCSrcM     = pc_src_reg;
    assign ALUOutM    = alu_out_reg;
    assign WriteDataM = write_data_reg;
    assign WA3M       = wa3_reg;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Self-checking bench for cond_exec_stage: reference model feeds a scoreboard
// queue each cycle; registered outputs are compared after the following edge.
module tb_cond_exec_stage;

    localparam int BITS = 32;
    localparam int RA   = 4;

    logic            clk = 1'b0;
    logic            reset, StallM, FlushM;
    logic [3:0]      CondE;
    logic [1:0]      FlagWriteE;
    logic            RegWriteE, MemWriteE, MemtoRegE, PCSrcE;
    logic [3:0]      ALUFlags;
    logic [BITS-1:0] ALUResultE, WriteDataE;
    logic [RA-1:0]   WA3E;
    logic            CondExE, BranchTakenE;
    logic [3:0]      Flags;
    logic            RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
    logic [BITS-1:0] ALUOutM, WriteDataM;
    logic [RA-1:0]   WA3M;

    cond_exec_stage #(.BITS(BITS), .RA(RA)) dut (
        .clk(clk), .reset(reset), .StallM(StallM), .FlushM(FlushM),
        .CondE(CondE), .FlagWriteE(FlagWriteE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
        .PCSrcE(PCSrcE), .ALUFlags(ALUFlags), .ALUResultE(ALUResultE),
        .WriteDataE(WriteDataE), .WA3E(WA3E),
        .CondExE(CondExE), .BranchTakenE(BranchTakenE), .Flags(Flags),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .PCSrcM(PCSrcM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WA3M(WA3M)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      flags;
        logic            rw, mw, m2r, pcs;
        logic [BITS-1:0] alu, wd;
        logic [RA-1:0]   wa;
    } state_t;

    state_t mdl;
    state_t sb[$];
    int     checks = 0;
    int     errors = 0;
    logic   cond_seen, br_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, ge;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        ge = ~(n ^ v);
        if      (c == 4'd0)  return z;
        else if (c == 4'd1)  return !z;
        else if (c == 4'd2)  return cy;
        else if (c == 4'd3)  return !cy;
        else if (c == 4'd4)  return n;
        else if (c == 4'd5)  return !n;
        else if (c == 4'd6)  return v;
        else if (c == 4'd7)  return !v;
        else if (c == 4'd8)  return cy && !z;
        else if (c == 4'd9)  return !(cy && !z);
        else if (c == 4'd10) return ge;
        else if (c == 4'd11) return !ge;
        else if (c == 4'd12) return !z && ge;
        else if (c == 4'd13) return !(!z && ge);
        else if (c == 4'd14) return 1'b1;
        return 1'b0;
    endfunction

    // One pipeline cycle: drive, check combinational outputs mid-cycle, push the
    // model's expected post-edge state, then pop and compare after the edge.
    task automatic step(input logic rst, input logic stall, input logic flush,
                        input logic [3:0] cond, input logic [1:0] fw,
                        input logic rw, input logic mw, input logic m2r, input logic pcs,
                        input logic [3:0] af, input logic [BITS-1:0] alu,
                        input logic [BITS-1:0] wd, input logic [RA-1:0] wa);
        state_t nxt, got;
        logic   pass;
        reset = rst; StallM = stall; FlushM = flush; CondE = cond; FlagWriteE = fw;
        RegWriteE = rw; MemWriteE = mw; MemtoRegE = m2r; PCSrcE = pcs;
        ALUFlags = af; ALUResultE = alu; WriteDataE = wd; WA3E = wa;
        @(negedge clk);
        cond_seen = CondExE;
        br_seen   = BranchTakenE;
        pass = ref_cond(cond, mdl.flags);
        if (!$isunknown(mdl.flags)) begin
            chk("condex", {63'd0, CondExE}, {63'd0, pass});
            chk("branch_taken", {63'd0, BranchTakenE}, {63'd0, pcs & pass & ~flush});
        end
        nxt = mdl;
        if (rst) begin
            nxt.flags = 4'b0; nxt.rw = 0; nxt.mw = 0; nxt.m2r = 0; nxt.pcs = 0;
            nxt.alu = '0; nxt.wd = '0; nxt.wa = '0;
        end else if (stall) begin
            nxt = mdl;
        end else if (flush) begin
            nxt.rw = 0; nxt.mw = 0; nxt.m2r = 0; nxt.pcs = 0;
            nxt.alu = '0; nxt.wd = '0; nxt.wa = '0;
        end else begin
            if (pass && fw[1]) nxt.flags[3:2] = af[3:2];
            if (pass && fw[0]) nxt.flags[1:0] = af[1:0];
            nxt.rw = rw & pass; nxt.mw = mw & pass; nxt.pcs = pcs & pass;
            nxt.m2r = m2r; nxt.alu = alu; nxt.wd = wd; nxt.wa = wa;
        end
        sb.push_back(nxt);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("flags",      {60'd0, Flags},      {60'd0, got.flags});
        chk("regwrite_m", {63'd0, RegWriteM},  {63'd0, got.rw});
        chk("memwrite_m", {63'd0, MemWriteM},  {63'd0, got.mw});
        chk("memtoreg_m", {63'd0, MemtoRegM},  {63'd0, got.m2r});
        chk("pcsrc_m",    {63'd0, PCSrcM},     {63'd0, got.pcs});
        chk("aluout_m",   {32'd0, ALUOutM},    {32'd0, got.alu});
        chk("wdata_m",    {32'd0, WriteDataM}, {32'd0, got.wd});
        chk("wa3_m",      {60'd0, WA3M},       {60'd0, got.wa});
        mdl = got;
    endtask

    task automatic rand_step(input logic rst, input logic stall, input logic flush);
        step(rst, stall, flush, 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom, RA'($urandom));
    endtask

    // rst stall flush cond fw rw mw m2r pcs af alu wd wa
    initial begin
        mdl.flags = 'x; mdl.rw = 'x; mdl.mw = 'x; mdl.m2r = 'x; mdl.pcs = 'x;
        mdl.alu = 'x; mdl.wd = 'x; mdl.wa = 'x;

        rand_step(1, 1'($urandom), 1'($urandom));
        rand_step(1, 1'($urandom), 1'($urandom));
        chk("reset_flags", {60'd0, Flags}, 64'd0);
        chk("reset_regwrite", {63'd0, RegWriteM}, 64'd0);
        chk("reset_aluout", {32'd0, ALUOutM}, 64'd0);

        step(0, 0, 0, 4'hE, 2'b00, 1, 0, 0, 0, 4'b0000, 32'h12345678, 32'h0, 4'h3);
        chk("first_regwrite", {63'd0, RegWriteM}, 64'd1);
        chk("first_aluout", {32'd0, ALUOutM}, 64'h12345678);

        // CMP sets Z, then BEQ taken; then CMP clears Z, BEQ not taken
        step(0, 0, 0, 4'hE, 2'b11, 0, 0, 0, 0, 4'b0100, 32'h0, 32'h0, 4'h0);
        step(0, 0, 0, 4'h0, 2'b00, 0, 0, 0, 1, 4'b0000, 32'h40, 32'h0, 4'h0);
        chk("beq_condex", {63'd0, cond_seen}, 64'd1);
        chk("beq_taken", {63'd0, br_seen}, 64'd1);
        chk("beq_pcsrc_m", {63'd0, PCSrcM}, 64'd1);
        step(0, 0, 0, 4'hE, 2'b11, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 4'h0);
        step(0, 0, 0, 4'h0, 2'b00, 0, 0, 0, 1, 4'b0000, 32'h40, 32'h0, 4'h0);
        chk("bne_taken", {63'd0, br_seen}, 64'd0);
        chk("bne_pcsrc_m", {63'd0, PCSrcM}, 64'd0);

        // Independent flag halves
        step(0, 0, 0, 4'hE, 2'b11, 0, 0, 0, 0, 4'b1111, 32'h0, 32'h0, 4'h0);
        step(0, 0, 0, 4'hE, 2'b01, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 4'h0);
        chk("partial_cv", {60'd0, Flags}, 64'hC);
        step(0, 0, 0, 4'hE, 2'b10, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 4'h0);
        chk("partial_nz", {60'd0, Flags}, 64'h0);

        // Failing EQ suppresses writes and flag update
        step(0, 0, 0, 4'h0, 2'b11, 1, 1, 0, 0, 4'b1111, 32'h5, 32'h6, 4'h7);
        chk("fail_regwrite", {63'd0, RegWriteM}, 64'd0);
        chk("fail_memwrite", {63'd0, MemWriteM}, 64'd0);
        chk("fail_flags", {60'd0, Flags}, 64'd0);
        step(0, 0, 0, 4'hE, 2'b11, 0, 0, 0, 0, 4'b1111, 32'h0, 32'h0, 4'h0);
        step(0, 0, 0, 4'hF, 2'b11, 1, 1, 0, 1, 4'b0000, 32'h0, 32'h0, 4'h0);
        chk("never_condex", {63'd0, cond_seen}, 64'd0);

        // Signed comparisons: N=1 V=0
        step(0, 0, 0, 4'hE, 2'b11, 0, 0, 0, 0, 4'b1000, 32'h0, 32'h0, 4'h0);
        step(0, 0, 0, 4'hA, 2'b00, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 4'h0);
        chk("ge_nv10", {63'd0, cond_seen}, 64'd0);
        step(0, 0, 0, 4'hB, 2'b00, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 4'h0);
        chk("lt_nv10", {63'd0, cond_seen}, 64'd1);
        step(0, 0, 0, 4'hC, 2'b00, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 4'h0);
        chk("gt_nv10", {63'd0, cond_seen}, 64'd0);
        step(0, 0, 0, 4'hD, 2'b00, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 4'h0);
        chk("le_nv10", {63'd0, cond_seen}, 64'd1);
        // N=1 V=1 Z=0
        step(0, 0, 0, 4'hE, 2'b11, 0, 0, 0, 0, 4'b1001, 32'h0, 32'h0, 4'h0);
        step(0, 0, 0, 4'hA, 2'b00, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 4'h0);
        chk("ge_nv11", {63'd0, cond_seen}, 64'd1);
        step(0, 0, 0, 4'hC, 2'b00, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 4'h0);
        chk("gt_nv11", {63'd0, cond_seen}, 64'd1);
        // HI with C=1 Z=1
        step(0, 0, 0, 4'hE, 2'b11, 0, 0, 0, 0, 4'b0110, 32'h0, 32'h0, 4'h0);
        step(0, 0, 0, 4'h8, 2'b00, 1, 0, 1, 0, 4'b0000, 32'hCAFE0001, 32'hBEEF0002, 4'h9);
        chk("hi_cz11", {63'd0, cond_seen}, 64'd0);

        // Stall holds everything, also with flush asserted
        for (int i = 0; i < 3; i++) rand_step(0, 1, 0);
        rand_step(0, 1, 1);
        chk("stall_aluout", {32'd0, ALUOutM}, 64'hCAFE0001);
        chk("stall_flags", {60'd0, Flags}, 64'h6);

        // Flush: bubble, no branch, flags untouched
        step(0, 0, 1, 4'hE, 2'b11, 1, 1, 1, 1, 4'b1111, 32'h77, 32'h88, 4'hA);
        chk("flush_branch", {63'd0, br_seen}, 64'd0);
        chk("flush_pcsrc_m", {63'd0, PCSrcM}, 64'd0);
        chk("flush_regwrite_m", {63'd0, RegWriteM}, 64'd0);
        chk("flush_flags", {60'd0, Flags}, 64'h6);

        // Reset overrides a simultaneous stall/flush
        step(0, 0, 0, 4'hE, 2'b11, 1, 1, 1, 1, 4'b1111, 32'h77, 32'h88, 4'hA);
        step(1, 1, 1, 4'hE, 2'b11, 1, 1, 1, 1, 4'b1111, 32'h77, 32'h88, 4'hA);
        chk("rst_stall_flags", {60'd0, Flags}, 64'd0);
        chk("rst_stall_aluout", {32'd0, ALUOutM}, 64'd0);

        for (int i = 0; i < 300; i++)
            rand_step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 5) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cond_exec_stage.md
Name: cond_exec_stage

Overview:
Execute-stage back end, directly downstream of the ALU. It holds the architectural NZCV flag register and evaluates the 4-bit condition field of the instruction in Execute against those flags. It gates that instruction's side effects: register write, memory write, branch and flag update. It also provides the Execute/Memory pipeline register that carries the ALU result and the gated controls into the Memory stage.

Parameters:
BITS, 32, datapath width of the ALU result and store data
RA, 4, register-address width of the destination tag

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
StallM  in  1  hold all state (flags and M registers) this cycle
FlushM  in  1  squash the Execute instruction: bubble into M, no flag update
CondE  in  4  condition field of the Execute instruction
FlagWriteE  in  2  [1]: update N,Z; [0]: update C,V
RegWriteE, MemWriteE, MemtoRegE, PCSrcE  in  1 each  ungated decode controls
ALUFlags  in  4  ALU flags this cycle: [3]N [2]Z [1]C [0]V
ALUResultE  in  BITS  ALU result
WriteDataE  in  BITS  store data
WA3E  in  RA  destination register
CondExE  out  1  combinational: condition passes
BranchTakenE  out  1  combinational: PCSrcE & CondExE & ~FlushM
Flags  out  4  registered NZCV, same bit order as ALUFlags
RegWriteM, MemWriteM, MemtoRegM, PCSrcM  out  1 each  registered gated controls
ALUOutM, WriteDataM  out  BITS  registered data
WA3M  out  RA  registered destination

Behaviour:
- Reset (sync, highest priority): Flags=0000; all M outputs = 0.
- Priority each edge: reset > StallM > FlushM > normal.
- StallM=1: every register holds, including Flags. Combinational outputs are still evaluated.
- CondExE is evaluated against the registered Flags, never against ALUFlags of the same cycle.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: ~Z
  - 2 CS: C
  - 3 CC: ~C
  - 4 MI: N
  - 5 PL: ~N
  - 6 VS: V
  - 7 VC: ~V
  - 8 HI: C&~Z
  - 9 LS: ~C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: ~Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: never, CondExE=0
- Flag update, normal cycle with CondExE=1:
  - FlagWriteE[1]=1: Flags[3:2] <= ALUFlags[3:2].
  - FlagWriteE[0]=1: Flags[1:0] <= ALUFlags[1:0].
  - The two halves are independent. A failing condition updates neither half.
- M register, normal cycle:
  - RegWriteM <= RegWriteE & CondExE; MemWriteM <= MemWriteE & CondExE; PCSrcM <= PCSrcE & CondExE.
  - MemtoRegM, ALUOutM, WriteDataM, WA3M load unconditionally.
- FlushM (no stall): all M outputs load 0; Flags unchanged; BranchTakenE=0.
- Latency:
  - Flags written at edge N are visible to CondExE from cycle N+1. Back-to-back CMP→conditional instruction needs no forwarding.
  - Data and controls: 1 cycle E→M.
- Reset asserted mid-stall or mid-flush: reset wins, all state cleared in that edge.
- Widths: RA and BITS are pass-through only; no arithmetic in this block.

Test Plan:
- Reset: hold reset 2 cycles with random inputs -> Flags=0000, all M outputs 0. Release; CondE=E, RegWriteE=1, ALUResultE=0x12345678 -> next cycle RegWriteM=1, ALUOutM=0x12345678.
- CMP then BEQ: cycle 1 CondE=E, FlagWriteE=11, ALUFlags=0100. Cycle 2 CondE=0, PCSrcE=1 -> cycle 2 CondExE=1, BranchTakenE=1; next edge PCSrcM=1. Repeat with ALUFlags=0000 -> BranchTakenE=0, PCSrcM=0.
- Partial write: Flags=1111; CondE=E, FlagWriteE=01, ALUFlags=0000 -> Flags=1100. Then FlagWriteE=10 -> Flags=0000.
- Failing condition: Flags=0000, CondE=0 (EQ), RegWriteE=1, MemWriteE=1, FlagWriteE=11, ALUFlags=1111 -> RegWriteM=0, MemWriteM=0, Flags still 0000. CondE=F with any flags -> CondExE=0.
- Signed conditions:
  - Flags N=1,V=0: GE=0, LT=1, GT=0, LE=1.
  - Flags N=1,V=1,Z=0: GE=1, GT=1.
  - HI with C=1,Z=1 -> 0.
- Stall/flush:
  - StallM=1 for 3 cycles while inputs change -> M outputs and Flags frozen.
  - StallM=1 & FlushM=1 -> hold, not bubble.
  - FlushM=1 with CondE=E, FlagWriteE=11, PCSrcE=1 -> BranchTakenE=0, M outputs 0 next cycle, Flags unchanged.
